// File: rtl/load_buffer.sv
// In-order load buffer: compact queue of address-computed loads, one memory
// request outstanding at a time, results broadcast on the CDB.
package load_buffer_pkg;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned ROB_TAG_W = 5;

  typedef struct packed {
    logic                 valid;
    logic                 speculative;
    logic [XLEN-1:0]      npc;
    logic [31:0]          inst;
    logic [XLEN-1:0]      address;
    logic [ROB_TAG_W-1:0] rd_tag;
    logic [2:0]           mem_size;
  } lb_packet_t;

  typedef struct packed {
    logic                 valid;
    logic                 speculative;
    logic [XLEN-1:0]      npc;
    logic [31:0]          inst;
    logic [XLEN-1:0]      value;
    logic [ROB_TAG_W-1:0] rob_tag;
  } ex_wr_packet_t;
endpackage

module load_buffer
  import load_buffer_pkg::*;
#(
  parameter int unsigned LB_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  lb_packet_t      lb_packet_i,
  input  logic            kill_i,
  input  logic            resolve_i,
  output logic            lb_full_o,
  output logic            mem_req_valid_o,
  output logic [XLEN-1:0] mem_req_addr_o,
  input  logic            mem_req_ack_i,
  input  logic            mem_resp_valid_i,
  input  logic [XLEN-1:0] mem_resp_data_i,
  output ex_wr_packet_t   load_result_o,
  input  logic            cdb_grant_i
);

  localparam int unsigned CNT_W = $clog2(LB_DEPTH + 1);
  localparam int unsigned IDX_W = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_BCAST, S_DRAIN} state_e;

  state_e          state_q, state_d;
  lb_packet_t      entries_q [LB_DEPTH];
  lb_packet_t      entries_d [LB_DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic [XLEN-1:0] value_q, value_d;

  logic             kill_head;
  logic             enq, deq;
  logic [CNT_W-1:0] nonspec_cnt;

  // Select and extend the addressed byte/half out of an aligned word.
  function automatic logic [XLEN-1:0] extract(input logic [2:0] f3,
                                              input logic [1:0] off,
                                              input logic [XLEN-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b010:  extract = w;
      3'b100:  extract = {24'h0, b};
      3'b101:  extract = {16'h0, h};
      default: extract = 32'hfacebeec;
    endcase
  endfunction

  assign lb_full_o = (count_q == CNT_W'(LB_DEPTH));
  assign kill_head = kill_i && entries_q[0].valid && entries_q[0].speculative;
  assign deq       = (state_q == S_BCAST) && cdb_grant_i && !kill_head;
  assign enq       = lb_packet_i.valid && !lb_full_o && !(kill_i && lb_packet_i.speculative);

  // Queue update order: squash/resolve, then shift out head, then append at tail.
  always_comb begin
    entries_d   = entries_q;
    count_d     = count_q;
    nonspec_cnt = '0;
    for (int unsigned i = 0; i < LB_DEPTH; i++) begin
      if (entries_q[IDX_W'(i)].valid && !entries_q[IDX_W'(i)].speculative) begin
        nonspec_cnt = nonspec_cnt + CNT_W'(1);
      end
    end
    if (kill_i) begin
      for (int unsigned i = 0; i < LB_DEPTH; i++) begin
        if (entries_d[IDX_W'(i)].speculative) entries_d[IDX_W'(i)] = '0;
      end
      count_d = nonspec_cnt;
    end else if (resolve_i) begin
      for (int unsigned i = 0; i < LB_DEPTH; i++) begin
        entries_d[IDX_W'(i)].speculative = 1'b0;
      end
    end
    if (deq) begin
      for (int unsigned i = 0; i + 1 < LB_DEPTH; i++) begin
        entries_d[IDX_W'(i)] = entries_d[IDX_W'(i + 1)];
      end
      entries_d[IDX_W'(LB_DEPTH - 1)] = '0;
      count_d = count_d - CNT_W'(1);
    end
    if (enq) begin
      entries_d[IDX_W'(count_d)] = lb_packet_i;
      count_d = count_d + CNT_W'(1);
    end
  end

  // Issue FSM for the head entry.
  always_comb begin
    state_d = state_q;
    value_d = value_q;
    case (state_q)
      S_IDLE:  if (count_q != '0 && !kill_head) state_d = S_REQ;
      S_REQ: begin
        // A request accepted in the same cycle it is squashed still owes a response.
        if (kill_head)          state_d = mem_req_ack_i ? S_DRAIN : S_IDLE;
        else if (mem_req_ack_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (kill_head) begin
          state_d = mem_resp_valid_i ? S_IDLE : S_DRAIN;
        end else if (mem_resp_valid_i) begin
          state_d = S_BCAST;
          value_d = extract(entries_q[0].mem_size, entries_q[0].address[1:0], mem_resp_data_i);
        end
      end
      S_BCAST: if (kill_head || cdb_grant_i) state_d = S_IDLE;
      S_DRAIN: if (mem_resp_valid_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      value_q   <= '0;
      entries_q <= '{default: '0};
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      value_q   <= value_d;
      entries_q <= entries_d;
    end
  end

  assign mem_req_valid_o = (state_q == S_REQ);
  assign mem_req_addr_o  = (state_q == S_REQ) ? {entries_q[0].address[XLEN-1:2], 2'b00} : '0;

  always_comb begin
    load_result_o = '0;
    if (state_q == S_BCAST && !kill_head) begin
      load_result_o.valid       = 1'b1;
      load_result_o.speculative = resolve_i ? 1'b0 : entries_q[0].speculative;
      load_result_o.npc         = entries_q[0].npc;
      load_result_o.inst        = entries_q[0].inst;
      load_result_o.value       = value_q;
      load_result_o.rob_tag     = entries_q[0].rd_tag;
    end
  end

  // Upstream must never present a load while the buffer is full.
  a_no_enq_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(lb_packet_i.valid && lb_full_o));

endmodule

// File: tb/tb_load_buffer.sv
// Directed + randomized bench for load_buffer with a transaction-level
// reference model (queue of loads, spec-level extraction rules).
module tb_load_buffer;
  import load_buffer_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  lb_packet_t    lb_packet_i;
  logic          kill_i, resolve_i;
  logic          lb_full_o;
  logic          mem_req_valid_o;
  logic [31:0]   mem_req_addr_o;
  logic          mem_req_ack_i, mem_resp_valid_i;
  logic [31:0]   mem_resp_data_i;
  ex_wr_packet_t load_result_o;
  logic          cdb_grant_i;

  int checks = 0;
  int errors = 0;

  load_buffer #(.LB_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .lb_packet_i(lb_packet_i), .kill_i(kill_i),
    .resolve_i(resolve_i), .lb_full_o(lb_full_o), .mem_req_valid_o(mem_req_valid_o),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_ack_i(mem_req_ack_i),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_data_i(mem_resp_data_i),
    .load_result_o(load_result_o), .cdb_grant_i(cdb_grant_i)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, 128'(obs), 128'(exp));
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk(tag, 128'(obs), 128'(exp));
  endtask

  // Reference extraction written from the load semantics.
  function automatic logic [31:0] ref_value(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] w);
    logic [31:0] bsh, hsh;
    bsh = w >> (8 * addr[1:0]);
    hsh = w >> (16 * addr[1]);
    case (f3)
      3'd0:    return 32'($signed(bsh[7:0]));
      3'd1:    return 32'($signed(hsh[15:0]));
      3'd2:    return w;
      3'd4:    return 32'(bsh[7:0]);
      3'd5:    return 32'(hsh[15:0]);
      default: return 32'hfacebeec;
    endcase
  endfunction

  function automatic lb_packet_t mk(input logic spec, input logic [31:0] addr,
                                    input logic [2:0] f3, input logic [4:0] tag);
    lb_packet_t p;
    p.valid       = 1'b1;
    p.speculative = spec;
    p.npc         = $urandom;
    p.inst        = $urandom;
    p.address     = addr;
    p.rd_tag      = tag;
    p.mem_size    = f3;
    return p;
  endfunction

  function automatic ex_wr_packet_t exp_result(input lb_packet_t p, input logic [31:0] v,
                                               input logic spec);
    ex_wr_packet_t e;
    e.valid       = 1'b1;
    e.speculative = spec;
    e.npc         = p.npc;
    e.inst        = p.inst;
    e.value       = v;
    e.rob_tag     = p.rd_tag;
    return e;
  endfunction

  task automatic enq(input lb_packet_t p);
    lb_packet_i = p;
    tick();
    lb_packet_i = '0;
  endtask

  task automatic quiet(input int n);
    repeat (n) begin
      tick();
      chk1("quiet_req", mem_req_valid_o, 1'b0);
      chk1("quiet_bcast", load_result_o.valid, 1'b0);
    end
  endtask

  task automatic wait_req(input lb_packet_t p);
    int n = 0;
    while (mem_req_valid_o !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk1("req_seen", mem_req_valid_o, 1'b1);
    chk32("req_addr", mem_req_addr_o, {p.address[31:2], 2'b00});
  endtask

  task automatic reach_wait(input lb_packet_t p);
    wait_req(p);
    repeat ($urandom_range(0, 2)) begin
      tick();
      chk1("req_hold", mem_req_valid_o, 1'b1);
    end
    mem_req_ack_i = 1'b1;
    tick();
    mem_req_ack_i = 1'b0;
    chk1("req_released", mem_req_valid_o, 1'b0);
  endtask

  task automatic respond(input logic [31:0] word);
    mem_resp_valid_i = 1'b1;
    mem_resp_data_i  = word;
    tick();
    mem_resp_valid_i = 1'b0;
    mem_resp_data_i  = $urandom;
  endtask

  task automatic serve_from_wait(input lb_packet_t p, input logic [31:0] word,
                                 input logic [31:0] exp_val, input bit chk_full);
    ex_wr_packet_t e;
    repeat ($urandom_range(0, 2)) begin
      tick();
      chk1("wait_quiet", load_result_o.valid, 1'b0);
    end
    respond(word);
    e = exp_result(p, exp_val, p.speculative);
    chk("bcast", 128'(load_result_o), 128'(e));
    repeat ($urandom_range(0, 2)) begin
      tick();
      chk("bcast_hold", 128'(load_result_o), 128'(e));
    end
    if (chk_full) chk1("full_before_grant", lb_full_o, 1'b1);
    cdb_grant_i = 1'b1;
    tick();
    cdb_grant_i = 1'b0;
    chk1("post_grant", load_result_o.valid, 1'b0);
    if (chk_full) chk1("full_after_grant", lb_full_o, 1'b0);
  endtask

  task automatic serve_pkt(input lb_packet_t p, input logic [31:0] word,
                           input logic [31:0] exp_val, input bit chk_full);
    reach_wait(p);
    serve_from_wait(p, word, exp_val, chk_full);
  endtask

  task automatic serve_model(input lb_packet_t p);
    logic [31:0] w;
    w = $urandom;
    serve_pkt(p, w, ref_value(p.mem_size, p.address, w), 1'b0);
  endtask

  initial begin
    lb_packet_t    p, a, b, c, d, f, g;
    lb_packet_t    model_q[$];
    ex_wr_packet_t e;

    rst_n = 1'b0; lb_packet_i = '0; kill_i = 1'b0; resolve_i = 1'b0;
    mem_req_ack_i = 1'b0; mem_resp_valid_i = 1'b0; mem_resp_data_i = '0; cdb_grant_i = 1'b0;
    tick(); tick();
    chk1("rst_full", lb_full_o, 1'b0);
    chk1("rst_req_valid", mem_req_valid_o, 1'b0);
    chk32("rst_req_addr", mem_req_addr_o, 32'h0);
    chk("rst_result", 128'(load_result_o), 128'(0));
    rst_n = 1'b1;
    tick();

    // Signed byte at the top lane of the word.
    p = mk(1'b0, 32'h1003, 3'b000, 5'd3);
    enq(p);
    serve_pkt(p, 32'h80FF_FF12, 32'hFFFF_FF80, 1'b0);

    // Fill to full, LHU first; remaining loads checked in order.
    p = mk(1'b0, 32'h2002, 3'b101, 5'd1);
    enq(p);
    for (int i = 0; i < 3; i++) begin
      a = mk(1'b0, $urandom, 3'($urandom_range(0, 7)), 5'($urandom));
      model_q.push_back(a);
      enq(a);
    end
    chk1("full_after_4", lb_full_o, 1'b1);
    serve_pkt(p, 32'hBEEF_0000, 32'h0000_BEEF, 1'b1);
    while (model_q.size() > 0) serve_model(model_q.pop_front());
    quiet(2);

    // Kill while a non-speculative head waits: younger speculative pair goes away.
    a = mk(1'b0, $urandom, 3'd2, 5'd10);
    b = mk(1'b0, $urandom, 3'd0, 5'd11);
    c = mk(1'b1, $urandom, 3'd1, 5'd12);
    d = mk(1'b1, $urandom, 3'd4, 5'd13);
    enq(a); enq(b); enq(c); enq(d);
    reach_wait(a);
    kill_i = 1'b1;
    tick();
    kill_i = 1'b0;
    chk1("kill_full_drop", lb_full_o, 1'b0);
    f = mk(1'b0, $urandom, 3'd5, 5'd14);
    g = mk(1'b0, $urandom, 3'd3, 5'd15);
    enq(f);
    chk1("count3_not_full", lb_full_o, 1'b0);
    enq(g);
    chk1("count4_full", lb_full_o, 1'b1);
    begin
      logic [31:0] w;
      w = $urandom;
      serve_from_wait(a, w, ref_value(a.mem_size, a.address, w), 1'b0);
    end
    serve_model(b);
    serve_model(f);
    serve_model(g);
    quiet(4);

    // Speculative head killed in WAIT: next response is drained.
    p = mk(1'b1, $urandom, 3'd2, 5'd20);
    enq(p);
    reach_wait(p);
    kill_i = 1'b1;
    tick();
    kill_i = 1'b0;
    chk1("drain_no_req", mem_req_valid_o, 1'b0);
    chk1("drain_no_bcast", load_result_o.valid, 1'b0);
    respond($urandom);
    chk1("drained_no_bcast", load_result_o.valid, 1'b0);
    quiet(3);
    p = mk(1'b0, $urandom, 3'd1, 5'd21);
    enq(p);
    serve_model(p);

    // Speculative head killed in REQ; a speculative arrival that cycle is dropped.
    p = mk(1'b1, $urandom, 3'd0, 5'd22);
    enq(p);
    wait_req(p);
    kill_i = 1'b1;
    lb_packet_i = mk(1'b1, $urandom, 3'd2, 5'd23);
    tick();
    kill_i = 1'b0;
    lb_packet_i = '0;
    chk1("req_withdrawn", mem_req_valid_o, 1'b0);
    quiet(4);

    // Resolve during broadcast clears the speculative flag on the CDB.
    p = mk(1'b1, 32'h3001, 3'd4, 5'd24);
    enq(p);
    reach_wait(p);
    respond(32'h1234_5678);
    e = exp_result(p, 32'h0000_0056, 1'b1);
    chk("bcast_spec", 128'(load_result_o), 128'(e));
    resolve_i = 1'b1;
    #1;
    chk1("resolve_spec", load_result_o.speculative, 1'b0);
    chk1("resolve_valid", load_result_o.valid, 1'b1);
    cdb_grant_i = 1'b1;
    tick();
    resolve_i = 1'b0;
    cdb_grant_i = 1'b0;
    chk1("resolve_post_grant", load_result_o.valid, 1'b0);
    quiet(3);

    // Kill and grant together on a speculative head: kill wins.
    p = mk(1'b1, $urandom, 3'd7, 5'd25);
    enq(p);
    reach_wait(p);
    respond($urandom);
    chk32("bad_funct3", load_result_o.value, 32'hfacebeec);
    kill_i = 1'b1;
    cdb_grant_i = 1'b1;
    #1;
    chk1("kill_bcast_comb", load_result_o.valid, 1'b0);
    tick();
    kill_i = 1'b0;
    cdb_grant_i = 1'b0;
    chk1("kill_bcast_after", load_result_o.valid, 1'b0);
    quiet(3);

    // Randomized bursts against the model queue.
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        a = mk(1'b0, $urandom, 3'($urandom_range(0, 7)), 5'($urandom));
        model_q.push_back(a);
        enq(a);
      end
      chk1("rand_full", lb_full_o, (n == 4) ? 1'b1 : 1'b0);
      while (model_q.size() > 0) serve_model(model_q.pop_front());
    end

    // Reset in WAIT abandons the request; stray response ignored.
    p = mk(1'b0, $urandom, 3'd2, 5'd26);
    enq(p);
    enq(mk(1'b0, $urandom, 3'd2, 5'd27));
    reach_wait(p);
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_full", lb_full_o, 1'b0);
    chk1("mid_rst_req", mem_req_valid_o, 1'b0);
    chk32("mid_rst_addr", mem_req_addr_o, 32'h0);
    chk("mid_rst_result", 128'(load_result_o), 128'(0));
    tick();
    rst_n = 1'b1;
    tick();
    respond($urandom);
    chk1("stray_resp_ignored", load_result_o.valid, 1'b0);
    quiet(4);
    p = mk(1'b0, $urandom, 3'd5, 5'd28);
    enq(p);
    serve_model(p);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_buffer.md
LOAD_BUFFER -- requirements
Module: load_buffer

Interface
REQ-001 Parameter LB_DEPTH, default 4, SHALL set the number of queued load entries (minimum 2).
REQ-002 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 lb_packet_in  input  LB_PACKET  SHALL carry the load from the address calculation unit: valid, speculative, NPC, inst, address, rd_tag, mem_size (funct3).
REQ-005 kill  input  1  SHALL squash every speculative entry (mispredict).
REQ-006 resolve  input  1  SHALL clear the speculative bit of every entry (branch resolved correct).
REQ-007 lb_full  output  1  SHALL be high when all LB_DEPTH entries are occupied.
REQ-008 mem_req_valid  output  1; mem_req_addr  output  XLEN  (word-aligned); mem_req_ack  input  1 -- request handshake.
REQ-009 mem_resp_valid  input  1; mem_resp_data  input  XLEN  -- aligned 32-bit word returned one or more cycles after ack.
REQ-010 load_result  output  EX_WR_PACKET  SHALL be the CDB broadcast (valid, speculative, NPC, inst, value, rob_tag).
REQ-011 cdb_grant  input  1  SHALL indicate load_result is accepted this cycle.

Function
REQ-012 Queue SHALL stay compact: entry 0 is oldest; enqueue at index count; dequeue shifts all entries down by one.
REQ-013 A valid lb_packet_in SHALL enqueue at the clock edge when not full; a packet arriving while lb_full is high SHALL be dropped (upstream protocol violation, flagged by assertion).
REQ-014 Enqueue and dequeue in the same cycle SHALL leave count unchanged, new entry at index count-1.
REQ-015 Loads SHALL issue strictly in order from entry 0, one outstanding memory request at a time.
REQ-016 FSM states: IDLE, REQ, WAIT, BCAST, DRAIN.
REQ-017 IDLE -> REQ when count>0; REQ drives mem_req_valid=1, mem_req_addr={address[XLEN-1:2],2'b00}; REQ -> WAIT on mem_req_ack.
REQ-018 WAIT -> BCAST on mem_resp_valid; the extracted value SHALL be latched then.
REQ-019 Extraction: byte/half selected by address[1:0]; funct3 000 LB sign-extend, 001 LH sign-extend, 010 LW, 100 LBU zero-extend, 101 LHU zero-extend; other funct3 SHALL yield 32'hfacebeec.
REQ-020 BCAST SHALL drive load_result.valid=1, value, rob_tag=rd_tag, NPC, inst of entry 0; held stable until cdb_grant; on grant entry 0 dequeues and state -> IDLE (min. latency enqueue-to-broadcast: 3 cycles with same-cycle ack).
REQ-021 load_result.speculative SHALL be 0 when resolve is high, else entry 0 speculative bit (combinational).
REQ-022 kill SHALL invalidate all speculative entries at the edge; speculative entries are always the youngest, so count drops to the number of non-speculative entries.
REQ-023 kill with speculative head: in REQ -> IDLE (request withdrawn, mem_req_valid low next cycle); in WAIT -> DRAIN, discarding the next mem_resp_valid then -> IDLE; in BCAST load_result.valid SHALL drop combinationally that cycle and state -> IDLE.
REQ-024 kill and resolve in the same cycle: kill SHALL take priority.
REQ-025 A speculative lb_packet_in arriving with kill high SHALL be dropped.
REQ-026 kill and cdb_grant same cycle on speculative head: kill wins, no broadcast counted.
REQ-027 lb_full SHALL be combinational from registered count.

Reset
REQ-028 While reset is low: count=0, all entry valid bits 0, state IDLE, mem_req_valid=0, mem_req_addr=0, load_result all-zero, lb_full=0.
REQ-029 Reset asserted mid-operation (any state) SHALL abandon the outstanding request; a mem_resp_valid after reset release with no request outstanding SHALL be ignored.

Verification
REQ-030 Enqueue LB addr 0x1003, funct3 000; ack immediately; resp 0x80FF_FF12 -> load_result.value=0xFFFF_FF80, valid held until cdb_grant.
REQ-031 Fill 4 entries, LHU addr 0x2002 resp 0xBEEF_0000 first -> value 0x0000_BEEF, lb_full=1 until first grant; broadcasts in enqueue order.
REQ-032 Two non-spec + two spec entries, kill while head in WAIT (head non-spec) -> count=2, head completes normally.
REQ-033 Single speculative head in WAIT, kill -> DRAIN, response discarded, no load_result.valid, state IDLE.
REQ-034 Speculative head in BCAST with resolve high -> load_result.speculative=0; assert reset mid-WAIT -> all outputs zero, later resp ignored.
